thermal_sequencer: RTL and testbench

Sequences the Peltier cooler and the critical-shutdown path for the two-zone thermal subsystem.
- Samples zone A/B sensors on a divided tick and debounces the thresholds over consecutive samples.
- Applies hysteresis and minimum on/off dwell times so the Peltier does not chatter.
- Latches critical faults until software clears them.
- Sits between the raw sensor bus and the cooler driver / power-cut logic.

---
 rtl/thermal_pkg.sv | 15 +
 rtl/thermal_confirm.sv | 43 ++++
 rtl/thermal_sequencer.sv | 145 ++++++++++++++
 tb/tb_thermal_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/thermal_pkg.sv
// Shared constants for the two-zone thermal sequencer: state encoding and
// default temperature thresholds.
package thermal_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE     = 2'b00;
  localparam logic [STATE_W-1:0] ST_COOLING  = 2'b01;
  localparam logic [STATE_W-1:0] ST_SHUTDOWN = 2'b11;

  localparam logic [7:0] DEF_TEMP_LIMIT     = 8'd45;
  localparam logic [7:0] DEF_HYST           = 8'd3;
  localparam logic [7:0] DEF_CRITICAL_LIMIT = 8'd60;

endpackage

// File: rtl/thermal_confirm.sv
// Saturating consecutive-sample counter; confirmed reflects the count the
// register will hold after this edge.
module thermal_confirm #(
  parameter int unsigned N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic cond,
  input  logic clr,
  output logic confirmed
);

  localparam int unsigned CW = $clog2(N + 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  // A clear request wins over a coincident sample tick.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clr) begin
      w_cnt_nxt = '0;
    end else if (tick) begin
      if (!cond) begin
        w_cnt_nxt = '0;
      end else if (r_cnt != CW'(N)) begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign confirmed = (w_cnt_nxt == CW'(N));

endmodule

// File: rtl/thermal_sequencer.sv
// Peltier cooler / critical-shutdown sequencer: divided sampling, debounced
// thresholds with hysteresis, minimum dwell times and a latched fault state.
module thermal_sequencer
  import thermal_pkg::*;
#(
  parameter logic [7:0]  TEMP_LIMIT      = DEF_TEMP_LIMIT,
  parameter logic [7:0]  HYST            = DEF_HYST,
  parameter logic [7:0]  CRITICAL_LIMIT  = DEF_CRITICAL_LIMIT,
  parameter int unsigned SAMPLE_DIV      = 100,
  parameter int unsigned CONFIRM_SAMPLES = 4,
  parameter int unsigned MIN_ON_CYCLES   = 1000,
  parameter int unsigned MIN_OFF_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] temp_sensor_a,
  input  logic [7:0] temp_sensor_b,
  input  logic       fault_clear,
  output logic       peltier_enable,
  output logic       critical_shutdown,
  output logic [1:0] state_out
);

  localparam logic [7:0]  COOL_LIMIT = TEMP_LIMIT - HYST;
  localparam int unsigned DIV_W      = $clog2(SAMPLE_DIV);
  localparam int unsigned DWELL_MAX  = (MIN_ON_CYCLES > MIN_OFF_CYCLES) ?
                                       MIN_ON_CYCLES : MIN_OFF_CYCLES;
  localparam int unsigned DWELL_W    = (DWELL_MAX < 1) ? 1 : $clog2(DWELL_MAX + 1);

  if (HYST > TEMP_LIMIT) begin : g_hyst_chk
    $error("thermal_sequencer: HYST must not exceed TEMP_LIMIT");
  end
  if (SAMPLE_DIV < 2) begin : g_div_chk
    $error("thermal_sequencer: SAMPLE_DIV must be at least 2");
  end
  if (CONFIRM_SAMPLES < 1) begin : g_confirm_chk
    $error("thermal_sequencer: CONFIRM_SAMPLES must be at least 1");
  end

  logic [DIV_W-1:0]   r_div;
  logic [DWELL_W-1:0] r_dwell;
  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;
  logic               r_crit_last;
  logic               r_peltier;
  logic               r_crit_sd;
  logic               w_tick;
  logic               w_hot;
  logic               w_cool;
  logic               w_crit;
  logic               w_hot_conf;
  logic               w_cool_conf;
  logic               w_clr;
  logic               w_fault_exit;

  assign w_tick = (r_div == DIV_W'(SAMPLE_DIV - 1));
  assign w_hot  = (temp_sensor_a > TEMP_LIMIT) && (temp_sensor_b > TEMP_LIMIT);
  assign w_cool = (temp_sensor_a <= COOL_LIMIT) || (temp_sensor_b <= COOL_LIMIT);
  assign w_crit = (temp_sensor_a > CRITICAL_LIMIT) || (temp_sensor_b > CRITICAL_LIMIT);

  // Fault exit is decoded independently of the confirm outputs to keep the
  // counter-clear path free of combinational feedback.
  assign w_fault_exit = (r_state == ST_SHUTDOWN) && fault_clear && !r_crit_last &&
                        !(w_tick && w_crit);
  assign w_clr        = w_fault_exit;

  thermal_confirm #(.N(CONFIRM_SAMPLES)) u_hot_confirm (
    .clk       (clk),
    .rst       (rst),
    .tick      (w_tick),
    .cond      (w_hot),
    .clr       (w_clr),
    .confirmed (w_hot_conf)
  );

  thermal_confirm #(.N(CONFIRM_SAMPLES)) u_cool_confirm (
    .clk       (clk),
    .rst       (rst),
    .tick      (w_tick),
    .cond      (w_cool),
    .clr       (w_clr),
    .confirmed (w_cool_conf)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_hot_conf && (r_dwell >= DWELL_W'(MIN_OFF_CYCLES))) begin
          w_state_nxt = ST_COOLING;
        end
      end
      ST_COOLING: begin
        if (w_cool_conf && (r_dwell >= DWELL_W'(MIN_ON_CYCLES))) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHUTDOWN: begin
        if (w_fault_exit) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_tick && w_crit) begin
      w_state_nxt = ST_SHUTDOWN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Divider, dwell timer, last-sample crit flag and decoded outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div       <= '0;
      r_dwell     <= '0;
      r_crit_last <= 1'b0;
      r_peltier   <= 1'b0;
      r_crit_sd   <= 1'b0;
    end else begin
      r_div <= w_tick ? '0 : r_div + DIV_W'(1);
      if (w_state_nxt != r_state) begin
        r_dwell <= '0;
      end else if (r_dwell != DWELL_W'(DWELL_MAX)) begin
        r_dwell <= r_dwell + DWELL_W'(1);
      end
      if (w_tick) begin
        r_crit_last <= w_crit;
      end
      r_peltier <= (w_state_nxt != ST_IDLE);
      r_crit_sd <= (w_state_nxt == ST_SHUTDOWN);
    end
  end

  assign peltier_enable    = r_peltier;
  assign critical_shutdown = r_crit_sd;
  assign state_out         = r_state;

endmodule

// File: tb/tb_thermal_sequencer.sv
// Randomized and directed bench for thermal_sequencer against a cycle-level
// behavioural model built from the sequencing rules.
module tb_thermal_sequencer;

  localparam int SD   = 4;
  localparam int CONF = 3;
  localparam int MINT = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] temp_sensor_a = 8'd30;
  logic [7:0] temp_sensor_b = 8'd30;
  logic       fault_clear = 1'b0;
  logic       peltier_enable;
  logic       critical_shutdown;
  logic [1:0] state_out;

  int n_cmp = 0;
  int n_err = 0;

  // Model: 0 idle, 1 cooling, 2 shutdown
  int m_mode, m_phase, m_hot_run, m_cool_run, m_time_in, m_crit_last;

  thermal_sequencer #(
    .SAMPLE_DIV      (SD),
    .CONFIRM_SAMPLES (CONF),
    .MIN_ON_CYCLES   (MINT),
    .MIN_OFF_CYCLES  (MINT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .temp_sensor_a     (temp_sensor_a),
    .temp_sensor_b     (temp_sensor_b),
    .fault_clear       (fault_clear),
    .peltier_enable    (peltier_enable),
    .critical_shutdown (critical_shutdown),
    .state_out         (state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int a, input int b, input bit fc, input bit rs);
    bit tick, hot, cool, crit;
    int nxt;
    if (rs) begin
      m_mode = 0; m_phase = 0; m_hot_run = 0; m_cool_run = 0;
      m_time_in = 0; m_crit_last = 0;
      return;
    end
    tick    = (m_phase == SD - 1);
    m_phase = (m_phase + 1) % SD;
    hot  = (a > 45) && (b > 45);
    cool = (a <= 42) || (b <= 42);
    crit = (a > 60) || (b > 60);
    if (tick) begin
      m_hot_run  = hot  ? m_hot_run + 1  : 0;
      m_cool_run = cool ? m_cool_run + 1 : 0;
    end
    nxt = m_mode;
    if (tick && crit) nxt = 2;
    else if (m_mode == 0 && m_hot_run >= CONF && m_time_in >= MINT) nxt = 1;
    else if (m_mode == 1 && m_cool_run >= CONF && m_time_in >= MINT) nxt = 0;
    else if (m_mode == 2 && fc && m_crit_last == 0) begin
      nxt = 0;
      m_hot_run = 0;
      m_cool_run = 0;
    end
    if (tick) m_crit_last = crit ? 1 : 0;
    m_time_in = (nxt != m_mode) ? 0 : m_time_in + 1;
    m_mode = nxt;
  endtask

  task automatic cycle(input int a, input int b, input bit fc, input bit rs);
    temp_sensor_a = 8'(a);
    temp_sensor_b = 8'(b);
    fault_clear   = fc;
    rst           = rs;
    model_step(a, b, fc, rs);
    @(posedge clk);
    #1;
    chk("state_out", int'(state_out), (m_mode == 2) ? 3 : m_mode);
    chk("peltier_enable", int'(peltier_enable), (m_mode != 0) ? 1 : 0);
    chk("critical_shutdown", int'(critical_shutdown), (m_mode == 2) ? 1 : 0);
  endtask

  task automatic run(input int a, input int b, input int n);
    for (int i = 0; i < n; i++) cycle(a, b, 1'b0, 1'b0);
  endtask

  // Pulse fault_clear on a cycle that is not a sample tick.
  task automatic pulse_clear(input int a, input int b);
    if (m_phase == SD - 1) cycle(a, b, 1'b0, 1'b0);
    cycle(a, b, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    cycle(30, 30, 1'b0, 1'b1);
  endtask

  int temps[10];

  initial begin
    temps = '{30, 42, 43, 45, 46, 50, 60, 61, 255, 0};
    @(negedge clk);
    do_reset();
    do_reset();

    // Quiet idle
    run(30, 30, 100);
    chk("t1_idle", int'(state_out), 0);

    // Hot entry, then hysteresis band hold
    run(50, 50, 14);
    chk("t2_cooling", int'(state_out), 1);
    run(50, 45, 12);
    chk("t2_band_hold", int'(state_out), 1);
    run(42, 50, 30);
    chk("t2_back_idle", int'(state_out), 0);

    // Cool request inside minimum on time, then exactly at the cool threshold+1
    run(30, 30, 24);
    run(50, 50, 14);
    chk("t3_entered", int'(state_out), 1);
    run(42, 50, 6);
    chk("t3_dwell_hold", int'(state_out), 1);
    run(42, 50, 16);
    chk("t3_idle_after_dwell", int'(state_out), 0);
    run(30, 30, 24);
    run(50, 50, 14);
    run(43, 50, 40);
    chk("t3_43_stays", int'(state_out), 1);

    // Critical latch; exactly 60 is not critical
    run(61, 30, SD);
    chk("t4_shutdown", int'(critical_shutdown), 1);
    run(60, 60, 40);
    chk("t4_latched", int'(state_out), 3);

    // Fault clear blocked by a critical last sample, then accepted
    run(61, 30, SD);
    pulse_clear(30, 30);
    chk("t5_clear_ignored", int'(state_out), 3);
    run(30, 30, SD);
    pulse_clear(30, 30);
    chk("t5_cleared", int'(state_out), 0);
    run(50, 50, 40);

    // Reset from cooling and from shutdown
    do_reset();
    chk("t6_rst_cooling", int'(state_out), 0);
    run(30, 30, 3);
    run(255, 30, 1);
    chk("t6_first_tick", int'(state_out), 3);
    do_reset();
    chk("t6_rst_shutdown", int'(critical_shutdown), 0);

    // Randomized traffic around the thresholds
    for (int i = 0; i < 3000; i++) begin
      int a, b;
      bit fc, rs;
      a = temps[$urandom_range(0, 9)];
      b = temps[$urandom_range(0, 9)];
      if (a == 0) a = int'($urandom_range(0, 255));
      if (b == 0) b = int'($urandom_range(0, 255));
      if ((a > 60 || b > 60) && $urandom_range(0, 3) != 0) a = 40;
      rs = ($urandom_range(0, 499) == 0);
      fc = ($urandom_range(0, 7) == 0) && (m_phase != SD - 1);
      for (int k = 0; k < int'($urandom_range(1, 6)); k++) cycle(a, b, fc && (k == 0), rs && (k == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
